// File: rtl/md5_wb_blockq_if.sv
// Wishbone slave bundle for the MD5 block queue.
// The master drives the address, data and cycle strobes; the slave returns read data and a one-cycle ack or err.
interface md5_wb_blockq_if #(
  parameter int DW = 32,
  parameter int AW = 32
) ();
  logic [AW-1:0]   adr;
  logic [DW-1:0]   dat_w;
  logic [DW-1:0]   dat_r;
  logic [DW/8-1:0] sel;
  logic            cyc;
  logic            stb;
  logic            we;
  logic            ack;
  logic            err;

  modport master (output adr, dat_w, sel, cyc, stb, we, input dat_r, ack, err);
  modport slave  (input adr, dat_w, sel, cyc, stb, we, output dat_r, ack, err);
endinterface

// File: rtl/md5_wb_blockq.sv
// Wishbone block queue for a 512-bit hash core.
// Software fills a staging block and commits it into an NBUF-deep queue; an issue FSM hands blocks to the core and collects the digests.
module md5_wb_blockq #(
  parameter int DW       = 32,
  parameter int AW       = 32,
  parameter int NBUF     = 2,
  parameter int BLOCK_W  = 512,
  parameter int DIGEST_W = 128
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  md5_wb_blockq_if.slave      wb,
  output logic                int_o,
  output logic [BLOCK_W-1:0]  blk_o,
  output logic                blk_valid_o,
  input  logic                core_ready_i,
  input  logic [DIGEST_W-1:0] digest_i,
  input  logic                digest_valid_i,
  output logic                core_rst_o
);
  localparam int NW = BLOCK_W / DW;
  localparam int ND = DIGEST_W / DW;
  localparam int PW = $clog2(NBUF);
  localparam int CW = PW + 1;
  localparam int SW = (NW > 1) ? $clog2(NW) : 1;
  localparam int DI = (ND > 1) ? $clog2(ND) : 1;
  localparam logic [7:0] A_CTRL   = 8'd0;
  localparam logic [7:0] A_STATUS = 8'(NW + 1);
  localparam logic [7:0] A_DIG0   = 8'(NW + 2);
  localparam logic [7:0] A_CLR    = 8'(NW + 2 + ND);
  localparam logic [7:0] A_DONE   = 8'(NW + 3 + ND);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OFFER = 2'd1,
    ST_BUSY  = 2'd2
  } state_t;

  state_t              state_r, state_nx;
  logic [DW-1:0]       staging_r [NW];
  logic [BLOCK_W-1:0]  queue_r [NBUF];
  logic [PW-1:0]       head_r, tail_r;
  logic [CW-1:0]       count_r;
  logic [DIGEST_W-1:0] digest_r;
  logic [31:0]         blocks_done_r;
  logic [DW-1:0]       dat_r;
  logic                ack_r, err_r, int_r, blk_valid_r;
  logic                irq_en_r, pending_r, soft_d_r, core_rst_pulse_r;

  logic [BLOCK_W-1:0]  stage_flat_s;
  logic [DW-1:0]       dig_word_s [ND];
  logic [DW-1:0]       rdata_s;
  logic [31:0]         status_s;
  logic [7:0]          idx_s;
  logic [SW-1:0]       widx_s;
  logic [DI-1:0]       didx_s;
  logic acc_s, bad_s, wr_s, is_stage_s, is_dig_s, full_s, empty_s, busy_s;
  logic stage_we_s, ctrl_we_s, soft_s, push_s, clr_s, pop_s, capture_s;
  logic irq_en_nx, pending_nx;
  logic unused_s;

  assign unused_s = ^{wb.sel, wb.adr[AW-1:8]};

  assign full_s   = (count_r == CW'(NBUF));
  assign empty_s  = (count_r == CW'(0));
  assign busy_s   = (state_r != ST_IDLE);
  assign status_s = 32'({16'(count_r), 11'd0, full_s, empty_s, busy_s, pending_r});

  // Flatten staging (word 0 in the MSBs) and split the digest into bus words.
  always_comb begin
    stage_flat_s = {BLOCK_W{1'b0}};
    for (int k = 0; k < NW; k++) begin
      stage_flat_s[BLOCK_W-1-k*DW -: DW] = staging_r[k];
    end
    for (int j = 0; j < ND; j++) begin
      dig_word_s[j] = digest_r[DIGEST_W-1-j*DW -: DW];
    end
  end

  // Address decode, read mux and write strobes for the access being accepted.
  always_comb begin
    acc_s      = wb.cyc & wb.stb & ~ack_r & ~err_r;
    idx_s      = wb.adr[7:0];
    widx_s     = SW'(idx_s - 8'd1);
    didx_s     = DI'(idx_s - A_DIG0);
    is_stage_s = (idx_s >= 8'd1) && (idx_s <= 8'(NW));
    is_dig_s   = (idx_s >= A_DIG0) && (idx_s < A_CLR);
    bad_s      = 1'b0;
    rdata_s    = {DW{1'b0}};
    if (is_stage_s) begin
      rdata_s = staging_r[widx_s];
    end else if (is_dig_s) begin
      rdata_s = dig_word_s[didx_s];
      bad_s   = wb.we;
    end else begin
      case (idx_s)
        A_CTRL: begin
          rdata_s[2] = irq_en_r;
          // A lone COMMIT into a full queue is refused; a flush in the same write wins.
          bad_s = wb.we & wb.dat_w[0] & ~wb.dat_w[1] & full_s;
        end
        A_STATUS: begin
          rdata_s = DW'(status_s);
          bad_s   = wb.we;
        end
        A_CLR:   bad_s = 1'b0;
        A_DONE: begin
          rdata_s = DW'(blocks_done_r);
          bad_s   = wb.we;
        end
        default: bad_s = 1'b1;
      endcase
    end
    wr_s       = acc_s & wb.we & ~bad_s;
    stage_we_s = wr_s & is_stage_s;
    ctrl_we_s  = wr_s & (idx_s == A_CTRL);
    soft_s     = ctrl_we_s & wb.dat_w[1];
    push_s     = ctrl_we_s & wb.dat_w[0] & ~wb.dat_w[1];
    clr_s      = wr_s & (idx_s == A_CLR);
  end

  // Issue FSM next state, pop and digest-capture strobes.
  always_comb begin
    state_nx  = state_r;
    pop_s     = 1'b0;
    capture_s = 1'b0;
    if (soft_s) begin
      state_nx = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (count_r != CW'(0)) state_nx = ST_OFFER;
          else                   state_nx = ST_IDLE;
        end
        ST_OFFER: begin
          if (core_ready_i) begin
            pop_s    = 1'b1;
            state_nx = ST_BUSY;
          end else begin
            state_nx = ST_OFFER;
          end
        end
        ST_BUSY: begin
          if (digest_valid_i) begin
            capture_s = 1'b1;
            state_nx  = ST_IDLE;
          end else begin
            state_nx = ST_BUSY;
          end
        end
        default: state_nx = ST_IDLE;
      endcase
    end
    irq_en_nx  = ctrl_we_s ? wb.dat_w[2] : irq_en_r;
    pending_nx = capture_s ? 1'b1 : (clr_s ? 1'b0 : pending_r);
  end

  // Staging words and queue storage.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      for (int k = 0; k < NW; k++) staging_r[k] <= {DW{1'b0}};
      for (int b = 0; b < NBUF; b++) queue_r[b] <= {BLOCK_W{1'b0}};
    end else begin
      if (stage_we_s) staging_r[widx_s] <= wb.dat_w;
      if (push_s) queue_r[tail_r] <= stage_flat_s;
    end
  end

  // Queue pointers, occupancy and FSM state.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      head_r      <= PW'(0);
      tail_r      <= PW'(0);
      count_r     <= CW'(0);
      state_r     <= ST_IDLE;
      blk_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nx;
      blk_valid_r <= (state_nx == ST_OFFER);
      if (soft_s) begin
        head_r  <= PW'(0);
        tail_r  <= PW'(0);
        count_r <= CW'(0);
      end else begin
        if (push_s) tail_r <= tail_r + PW'(1);
        if (pop_s)  head_r <= head_r + PW'(1);
        case ({push_s, pop_s})
          2'b10:   count_r <= count_r + CW'(1);
          2'b01:   count_r <= count_r - CW'(1);
          default: count_r <= count_r;
        endcase
      end
    end
  end

  // Bus terminate, read data, digest capture, interrupt and core reset pulse.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ack_r            <= 1'b0;
      err_r            <= 1'b0;
      dat_r            <= {DW{1'b0}};
      irq_en_r         <= 1'b0;
      pending_r        <= 1'b0;
      int_r            <= 1'b0;
      digest_r         <= {DIGEST_W{1'b0}};
      blocks_done_r    <= 32'd0;
      soft_d_r         <= 1'b0;
      core_rst_pulse_r <= 1'b0;
    end else begin
      ack_r     <= acc_s & ~bad_s;
      err_r     <= acc_s & bad_s;
      dat_r     <= (acc_s & ~bad_s & ~wb.we) ? rdata_s : {DW{1'b0}};
      irq_en_r  <= irq_en_nx;
      pending_r <= pending_nx;
      int_r     <= irq_en_nx & pending_nx;
      // The core reset pulse lands on the cycle after the SOFT_RST ack.
      soft_d_r         <= soft_s;
      core_rst_pulse_r <= soft_d_r;
      if (capture_s) begin
        digest_r      <= digest_i;
        blocks_done_r <= blocks_done_r + 32'd1;
      end
    end
  end

  assign wb.ack      = ack_r;
  assign wb.err      = err_r;
  assign wb.dat_r    = dat_r;
  assign int_o       = int_r;
  assign blk_valid_o = blk_valid_r;
  assign blk_o       = queue_r[head_r];
  assign core_rst_o  = wb_rst_i | core_rst_pulse_r;
endmodule

// File: tb/tb_md5_wb_blockq.sv
// Scoreboard bench for md5_wb_blockq: bus expectations and issued blocks are queued at stimulus time
// and checked by separate monitors when the DUT terminates an access or hands a block to the core.
module tb_md5_wb_blockq;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [511:0] blk;
  logic         blk_valid;
  logic         core_ready = 1'b0;
  logic [127:0] digest = 128'd0;
  logic         digest_valid = 1'b0;
  logic         core_rst;
  logic         irq;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        err;
    logic        chk;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  string       nm_q[$];
  logic [31:0] blk_q[$];

  localparam logic [127:0] D_ABC = 128'h900150983cd24fb0d6963f7d28e17f72;
  localparam logic [127:0] D_C2  = 128'hC2C2C2C2_00000000_11111111_22222222;

  md5_wb_blockq_if #(.DW(32), .AW(32)) bus ();

  md5_wb_blockq #(.DW(32), .AW(32), .NBUF(2), .BLOCK_W(512), .DIGEST_W(128)) dut (
    .wb_clk_i       (clk),
    .wb_rst_i       (rst),
    .wb             (bus),
    .int_o          (irq),
    .blk_o          (blk),
    .blk_valid_o    (blk_valid),
    .core_ready_i   (core_ready),
    .digest_i       (digest),
    .digest_valid_i (digest_valid),
    .core_rst_o     (core_rst)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Bus monitor: every ack/err pops one expectation.
  always @(negedge clk) begin
    exp_t  e;
    string n;
    if (bus.ack || bus.err) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_term: ack=%0b err=%0b with nothing expected", bus.ack, bus.err);
      end else begin
        e = exp_q.pop_front();
        n = nm_q.pop_front();
        if (bus.err !== e.err || bus.ack === bus.err || (e.chk && bus.dat_r !== e.data)) begin
          errors++;
          $display("FAIL %s: got ack=%0b err=%0b data=%08h, want err=%0b data=%08h",
                   n, bus.ack, bus.err, bus.dat_r, e.err, e.data);
        end
      end
    end
  end

  // Block monitor: every core handshake pops the expected word 0.
  always @(negedge clk) begin
    logic [31:0] w;
    if (blk_valid && core_ready) begin
      checks++;
      if (blk_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_block: word0=%08h", blk[511:480]);
      end else begin
        w = blk_q.pop_front();
        if (blk[511:480] !== w) begin
          errors++;
          $display("FAIL block_word0: got %08h want %08h", blk[511:480], w);
        end
      end
    end
  end

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h want %08h", n, act, exp);
    end
  endtask

  task automatic wb_start(input logic we, input logic [7:0] adr, input logic [31:0] dat,
                          input logic exp_err, input logic exp_chk, input logic [31:0] exp_dat,
                          input string n);
    exp_t e;
    e.err = exp_err;
    e.chk = exp_chk;
    e.data = exp_dat;
    exp_q.push_back(e);
    nm_q.push_back(n);
    bus.adr   = {24'd0, adr};
    bus.dat_w = dat;
    bus.we    = we;
    bus.sel   = 4'hF;
    bus.cyc   = 1'b1;
    bus.stb   = 1'b1;
  endtask

  task automatic wb_finish(input string n);
    int   cnt = 0;
    logic done = 1'b0;
    while (!done && cnt < 8) begin
      @(posedge clk); #1;
      cnt++;
      if (bus.ack || bus.err) done = 1'b1;
    end
    bus.cyc = 1'b0;
    bus.stb = 1'b0;
    bus.we  = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s: no terminate within 8 cycles", n);
    end
  endtask

  task automatic wr(input logic [7:0] adr, input logic [31:0] dat, input string n);
    wb_start(1'b1, adr, dat, 1'b0, 1'b0, 32'd0, n);
    wb_finish(n);
  endtask

  task automatic wr_err(input logic [7:0] adr, input logic [31:0] dat, input string n);
    wb_start(1'b1, adr, dat, 1'b1, 1'b0, 32'd0, n);
    wb_finish(n);
  endtask

  task automatic rd(input logic [7:0] adr, input logic [31:0] exp, input string n);
    wb_start(1'b0, adr, 32'd0, 1'b0, 1'b1, exp, n);
    wb_finish(n);
  endtask

  task automatic rd_err(input logic [7:0] adr, input string n);
    wb_start(1'b0, adr, 32'd0, 1'b1, 1'b0, 32'd0, n);
    wb_finish(n);
  endtask

  // Core model: wait for an offered block and accept it for one cycle.
  task automatic serve_block();
    int cnt = 0;
    while (!blk_valid && cnt < 20) begin
      @(posedge clk); #1;
      cnt++;
    end
    if (!blk_valid) begin
      checks++;
      errors++;
      $display("FAIL serve_block: blk_valid_o not seen within 20 cycles");
    end
    core_ready = 1'b1;
    @(posedge clk); #1;
    core_ready = 1'b0;
  endtask

  task automatic send_digest(input logic [127:0] d);
    digest = d;
    digest_valid = 1'b1;
    @(posedge clk); #1;
    digest_valid = 1'b0;
  endtask

  initial begin
    bus.adr = 32'd0; bus.dat_w = 32'd0; bus.sel = 4'h0;
    bus.cyc = 1'b0;  bus.stb = 1'b0;    bus.we = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_core_rst", {31'd0, core_rst}, 32'd1);
    chk("rst_int", {31'd0, irq}, 32'd0);
    chk("rst_blk_valid", {31'd0, blk_valid}, 32'd0);
    chk("rst_ack", {31'd0, bus.ack}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    rd(8'd17, 32'h0000_0004, "status_after_reset");

    // Padded "abc" block through the queue
    for (int k = 1; k <= 16; k++) begin
      wr(8'(k), (k == 1) ? 32'h6162_6380 : ((k == 16) ? 32'h0000_0018 : 32'd0), "stage_wr");
    end
    rd(8'd1, 32'h6162_6380, "stage_rd_w1");
    rd(8'd16, 32'h0000_0018, "stage_rd_w16");
    blk_q.push_back(32'h6162_6380);
    wr(8'd0, 32'd1, "commit_abc");
    chk("blk_valid_in_ack_cycle", {31'd0, blk_valid}, 32'd0);
    @(posedge clk); #1;
    chk("blk_valid_after_push", {31'd0, blk_valid}, 32'd1);
    serve_block();
    send_digest(D_ABC);
    rd(8'd18, 32'h9001_5098, "digest_w0");
    rd(8'd19, 32'h3cd2_4fb0, "digest_w1");
    rd(8'd20, 32'hd696_3f7d, "digest_w2");
    rd(8'd21, 32'h28e1_7f72, "digest_w3");
    rd(8'd23, 32'd1, "blocks_done_1");
    rd(8'd17, 32'h0000_0005, "status_pending");
    chk("int_masked", {31'd0, irq}, 32'd0);

    // Fill to full with the core stalled, then drain in order
    wr(8'd22, 32'd0, "clr_pending");
    wr(8'd1, 32'h0000_00A1, "stage_a1");
    blk_q.push_back(32'h0000_00A1);
    wr(8'd0, 32'd1, "commit_a1");
    wr(8'd1, 32'h0000_00A2, "stage_a2");
    blk_q.push_back(32'h0000_00A2);
    wr(8'd0, 32'd1, "commit_a2");
    rd(8'd17, 32'h0001_000A, "status_full");
    wr(8'd1, 32'h0000_00A3, "stage_a3");
    wr_err(8'd0, 32'd1, "commit_when_full");
    rd(8'd17, 32'h0001_000A, "status_full_after_err");
    serve_block();
    send_digest(128'd1);
    serve_block();
    send_digest(128'd2);
    rd(8'd23, 32'd3, "blocks_done_3");

    // Interrupt rise and clear
    wr(8'd22, 32'd0, "clr_pending_2");
    wr(8'd0, 32'd4, "irq_enable");
    chk("int_idle", {31'd0, irq}, 32'd0);
    rd(8'd0, 32'h0000_0004, "ctrl_read");
    wr(8'd1, 32'h0000_00B1, "stage_b1");
    blk_q.push_back(32'h0000_00B1);
    wr(8'd0, 32'd5, "commit_b1");
    serve_block();
    digest = 128'd3;
    digest_valid = 1'b1;
    chk("int_before_digest", {31'd0, irq}, 32'd0);
    @(posedge clk); #1;
    digest_valid = 1'b0;
    chk("int_after_digest", {31'd0, irq}, 32'd1);
    wr(8'd22, 32'd0, "clr_pending_irq");
    @(posedge clk); #1;
    chk("int_after_clear", {31'd0, irq}, 32'd0);

    // COMMIT accepted on the same edge as the OFFER handshake
    wr(8'd1, 32'h0000_00C1, "stage_c1");
    blk_q.push_back(32'h0000_00C1);
    wr(8'd0, 32'd5, "commit_c1");
    wr(8'd1, 32'h0000_00C2, "stage_c2");
    blk_q.push_back(32'h0000_00C2);
    @(posedge clk); #1;
    wb_start(1'b1, 8'd0, 32'd5, 1'b0, 1'b0, 32'd0, "commit_during_pop");
    core_ready = 1'b1;
    wb_finish("commit_during_pop");
    core_ready = 1'b0;
    rd(8'd17, 32'h0000_8002, "status_push_pop");
    send_digest(128'd4);
    serve_block();
    send_digest(D_C2);

    // SOFT_RST while BUSY with one block queued
    wr(8'd1, 32'h0000_00D1, "stage_d1");
    blk_q.push_back(32'h0000_00D1);
    wr(8'd0, 32'd5, "commit_d1");
    serve_block();
    wr(8'd1, 32'h0000_00D2, "stage_d2");
    wr(8'd0, 32'd5, "commit_d2");
    rd(8'd17, 32'h0000_8003, "status_busy_queued");
    wr(8'd0, 32'd6, "soft_rst");
    chk("core_rst_ack_cycle", {31'd0, core_rst}, 32'd0);
    @(posedge clk); #1;
    chk("core_rst_pulse", {31'd0, core_rst}, 32'd1);
    @(posedge clk); #1;
    chk("core_rst_pulse_end", {31'd0, core_rst}, 32'd0);
    rd(8'd17, 32'h0000_0005, "status_after_soft_rst");
    send_digest(128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF);
    repeat (3) @(posedge clk);
    #1;
    chk("no_issue_after_flush", {31'd0, blk_valid}, 32'd0);
    chk("int_kept", {31'd0, irq}, 32'd1);
    rd(8'd23, 32'd6, "blocks_done_after_late_digest");
    rd(8'd18, 32'hC2C2_C2C2, "digest_kept");
    rd(8'd1, 32'h0000_00D2, "staging_kept");
    rd(8'd0, 32'h0000_0004, "irq_en_kept");
    rd_err(8'd30, "rd_unmapped");
    wr_err(8'd17, 32'd0, "wr_status");
    wr_err(8'd18, 32'd0, "wr_digest");
    wr_err(8'd23, 32'd0, "wr_blocks_done");

    repeat (3) @(posedge clk);
    chk("bus_exp_drained", exp_q.size(), 32'd0);
    chk("blk_exp_drained", blk_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
